retire_trace_buffer: RTL and testbench

Retirement trace capture stage downstream of the 5-stage RISC-V pipeline core. Consumes the core's write-back debug outputs (valid, pc, imm, register numbers, exception), tags each retired instruction with a sequence number, and buffers it in a show-ahead FIFO drained by a valid/ready consumer (testbench logger or trace port). Counts retired and dropped instructions and freezes capture on the first exception, because the core holds its WB stage (and thus valid/exception) constant after an exception.

---
 rtl/sim_trace_pkg.sv | 25 ++
 rtl/trace_fifo.sv | 68 ++++++
 rtl/retire_trace_buffer.sv | 153 +++++++++++++++
 tb/tb_retire_trace_buffer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sim_trace_pkg.sv
// Shared types for the retirement trace capture stage: the buffered trace
// entry layout and the capture state machine encoding.
package sim_trace_pkg;

  // Width of the sequence field carried in every trace entry. Sequence
  // counters up to this width are stored without loss.
  localparam int SEQ_W = 32;

  typedef struct packed {
    logic [31:0]      pc;
    logic [31:0]      imm;
    logic [4:0]       rs1n;
    logic [4:0]       rs2n;
    logic [4:0]       rdn;
    logic [SEQ_W-1:0] seq;
    logic             last;
  } trace_entry_t;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    HALTED  = 2'd1,
    DRAINED = 2'd2
  } trace_state_t;

endpackage

// File: rtl/trace_fifo.sv
// Show-ahead synchronous FIFO. The head entry is presented combinationally
// from the storage array. A push into a full FIFO is accepted only when a pop
// happens in the same cycle, so the occupancy stays at DEPTH.
module trace_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  din_i,
  output logic [W-1:0]  dout_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   level_o
);

  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic [W-1:0] mem_q [DEPTH];
  logic         push_fire_s;
  logic         pop_fire_s;

  // Pointers carry one extra bit so full and empty are distinguishable.
  assign level_o     = wr_ptr_q - rd_ptr_q;
  assign full_o      = (level_o == (AW+1)'(DEPTH));
  assign empty_o     = (level_o == {(AW+1){1'b0}});
  assign pop_fire_s  = pop_i & ~empty_o;
  assign push_fire_s = push_i & (~full_o | pop_fire_s);
  assign dout_o      = mem_q[rd_ptr_q[AW-1:0]];

  // Next-state pointer arithmetic for accepted pushes and pops.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_fire_s) begin
      wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_fire_s) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // Pointer registers; reset empties the FIFO and wins over any push/pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= {(AW+1){1'b0}};
      rd_ptr_q <= {(AW+1){1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents are not cleared so the head holds stable data.
  always_ff @(posedge clk) begin
    if (!rst && push_fire_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= din_i;
    end
  end

endmodule

// File: rtl/retire_trace_buffer.sv
// Retirement trace capture: tags each retired instruction with a sequence
// number, buffers it for a valid/ready consumer, counts retired and dropped
// instructions, and freezes capture after the first exception because the
// core keeps repeating its write-back values from then on.
module retire_trace_buffer
  import sim_trace_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 32,
  localparam int LW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_exception,
  input  logic [31:0]      in_pc,
  input  logic [31:0]      in_imm,
  input  logic [4:0]       in_rs1n,
  input  logic [4:0]       in_rs2n,
  input  logic [4:0]       in_rdn,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_pc,
  output logic [31:0]      out_imm,
  output logic [4:0]       out_rs1n,
  output logic [4:0]       out_rs2n,
  output logic [4:0]       out_rdn,
  output logic [CNT_W-1:0] out_seq,
  output logic             out_last,
  output logic [CNT_W-1:0] retired_count,
  output logic [CNT_W-1:0] dropped_count,
  output logic [LW-1:0]    level,
  output logic             halted,
  output logic             last_lost
);

  trace_state_t     state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic [CNT_W-1:0] dropped_q, dropped_d;
  logic             last_lost_q, last_lost_d;

  logic             capture_s;
  logic             pop_fire_s;
  logic             drop_s;
  logic             full_s;
  logic             empty_s;
  logic [LW-1:0]    level_s;
  trace_entry_t     wr_entry_s;
  trace_entry_t     head_s;

  assign capture_s  = in_valid & (state_q == RUN);
  assign pop_fire_s = out_ready & ~empty_s;
  assign drop_s     = capture_s & full_s & ~pop_fire_s;

  // Assemble the entry written on a capture; seq is the pre-increment count.
  always_comb begin
    wr_entry_s      = '0;
    wr_entry_s.pc   = in_pc;
    wr_entry_s.imm  = in_imm;
    wr_entry_s.rs1n = in_rs1n;
    wr_entry_s.rs2n = in_rs2n;
    wr_entry_s.rdn  = in_rdn;
    wr_entry_s.seq  = SEQ_W'(retired_q);
    wr_entry_s.last = in_exception;
  end

  trace_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(trace_entry_t))
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (capture_s),
    .pop_i   (out_ready),
    .din_i   (wr_entry_s),
    .dout_o  (head_s),
    .full_o  (full_s),
    .empty_o (empty_s),
    .level_o (level_s)
  );

  // Statistics and sticky lost-exception flag next-state.
  always_comb begin
    retired_d   = retired_q;
    dropped_d   = dropped_q;
    last_lost_d = last_lost_q;
    if (capture_s) begin
      retired_d = retired_q + CNT_W'(1);
    end else begin
      retired_d = retired_q;
    end
    if (drop_s) begin
      dropped_d   = dropped_q + CNT_W'(1);
      last_lost_d = last_lost_q | in_exception;
    end else begin
      dropped_d   = dropped_q;
      last_lost_d = last_lost_q;
    end
  end

  // Capture state machine: RUN until an exception is captured, then drain.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (capture_s && in_exception) begin
          state_d = HALTED;
        end else begin
          state_d = RUN;
        end
      end
      HALTED: begin
        if (empty_s) begin
          state_d = DRAINED;
        end else begin
          state_d = HALTED;
        end
      end
      DRAINED: state_d = DRAINED;
      default: state_d = RUN;
    endcase
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      retired_q   <= {CNT_W{1'b0}};
      dropped_q   <= {CNT_W{1'b0}};
      last_lost_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      retired_q   <= retired_d;
      dropped_q   <= dropped_d;
      last_lost_q <= last_lost_d;
    end
  end

  assign out_valid     = ~empty_s;
  assign out_pc        = head_s.pc;
  assign out_imm       = head_s.imm;
  assign out_rs1n      = head_s.rs1n;
  assign out_rs2n      = head_s.rs2n;
  assign out_rdn       = head_s.rdn;
  assign out_seq       = CNT_W'(head_s.seq);
  assign out_last      = head_s.last;
  assign retired_count = retired_q;
  assign dropped_count = dropped_q;
  assign level         = level_s;
  assign halted        = (state_q != RUN);
  assign last_lost     = last_lost_q;

endmodule

// File: tb/tb_retire_trace_buffer.sv
// Self-checking bench for retire_trace_buffer: a scoreboard queue holds the
// entries expected at the FIFO head; a small reference model tracks counters
// and the capture state.
module tb_retire_trace_buffer;

  localparam int DEPTH = 16;
  localparam int CNT_W = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_exception;
  logic [31:0] in_pc, in_imm;
  logic [4:0]  in_rs1n, in_rs2n, in_rdn;
  logic        out_valid, out_ready;
  logic [31:0] out_pc, out_imm;
  logic [4:0]  out_rs1n, out_rs2n, out_rdn;
  logic [31:0] out_seq;
  logic        out_last;
  logic [31:0] retired_count, dropped_count;
  logic [4:0]  level;
  logic        halted, last_lost;

  always #5 clk = ~clk;

  retire_trace_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_exception(in_exception),
    .in_pc(in_pc), .in_imm(in_imm),
    .in_rs1n(in_rs1n), .in_rs2n(in_rs2n), .in_rdn(in_rdn),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_imm(out_imm),
    .out_rs1n(out_rs1n), .out_rs2n(out_rs2n), .out_rdn(out_rdn),
    .out_seq(out_seq), .out_last(out_last),
    .retired_count(retired_count), .dropped_count(dropped_count),
    .level(level), .halted(halted), .last_lost(last_lost)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [14:0] regs;
    logic [31:0] seq;
    logic        last;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int          m_state;   // 0 RUN, 1 HALTED, 2 DRAINED
  logic [31:0] m_ret, m_drop;
  logic        m_lost;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h", tag, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic e, input logic [31:0] pc);
    in_valid     = v;
    in_exception = e;
    in_pc        = pc;
    in_imm       = pc ^ 32'hA5A5_0F0F;
    in_rs1n      = pc[6:2];
    in_rs2n      = pc[11:7];
    in_rdn       = pc[4:0] ^ 5'h1F;
  endtask

  // Compare DUT against the model, advance the model, then clock one cycle.
  task automatic tick();
    exp_t e;
    int   sz;
    bit   pop_ok;
    sz = sb_q.size();
    check_eq("out_valid", out_valid, (sz != 0));
    check_eq("level", level, sz);
    check_eq("retired_count", retired_count, m_ret);
    check_eq("dropped_count", dropped_count, m_drop);
    check_eq("halted", halted, (m_state != 0));
    check_eq("last_lost", last_lost, m_lost);
    if (sz != 0) begin
      check_eq("head_pc", out_pc, sb_q[0].pc);
      check_eq("head_imm", out_imm, sb_q[0].imm);
      check_eq("head_regs", {out_rs1n, out_rs2n, out_rdn}, sb_q[0].regs);
      check_eq("head_seq", out_seq, sb_q[0].seq);
      check_eq("head_last", out_last, sb_q[0].last);
    end
    pop_ok = (sz != 0) && (out_ready === 1'b1);
    if (pop_ok) void'(sb_q.pop_front());
    if (in_valid && m_state == 0) begin
      if (sz < DEPTH || pop_ok) begin
        e.pc   = in_pc;
        e.imm  = in_imm;
        e.regs = {in_rs1n, in_rs2n, in_rdn};
        e.seq  = m_ret;
        e.last = in_exception;
        sb_q.push_back(e);
      end else begin
        m_drop++;
        if (in_exception) m_lost = 1'b1;
      end
      m_ret++;
      if (in_exception) m_state = 1;
    end else if (m_state == 1 && sz == 0) begin
      m_state = 2;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb_q.delete();
    m_state = 0;
    m_ret   = 32'd0;
    m_drop  = 32'd0;
    m_lost  = 1'b0;
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    drive(1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 40 && sb_q.size() != 0; i++) tick();
    tick();
    check_eq(tag, out_valid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    out_ready = 1'b0;
    drive(1'b0, 1'b0, 32'h0);
    do_reset();
    check_eq("rst_level", level, 5'd0);
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_halted", halted, 1'b0);

    // Three captures held, then drained on consecutive cycles.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 32'(i * 4));
      tick();
    end
    drive(1'b0, 1'b0, 32'h0);
    tick();
    check_eq("t1_level", level, 5'd3);
    check_eq("t1_retired", retired_count, 32'd3);
    check_eq("t1_head_pc", out_pc, 32'h0);
    check_eq("t1_head_seq", out_seq, 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check_eq("t1_empty", out_valid, 1'b0);

    // Overfill: 20 captures into 16 entries.
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b0, 32'(i * 4));
      tick();
    end
    drive(1'b0, 1'b0, 32'h0);
    tick();
    check_eq("t2_level", level, 5'd16);
    check_eq("t2_retired", retired_count, 32'd20);
    check_eq("t2_dropped", dropped_count, 32'd4);

    // Push and pop together at full.
    drive(1'b1, 1'b0, 32'h100);
    out_ready = 1'b1;
    tick();
    drive(1'b0, 1'b0, 32'h0);
    out_ready = 1'b0;
    tick();
    check_eq("t3_level", level, 5'd16);
    check_eq("t3_dropped", dropped_count, 32'd4);
    check_eq("t3_retired", retired_count, 32'd21);
    drain("t3_drained");

    // Exception capture, then the core repeats the same values.
    do_reset();
    out_ready = 1'b0;
    drive(1'b0, 1'b1, 32'h20);
    tick();
    check_eq("t4_exc_no_valid", retired_count, 32'd0);
    drive(1'b1, 1'b1, 32'h40);
    tick();
    for (int i = 0; i < 10; i++) tick();
    drive(1'b0, 1'b0, 32'h0);
    tick();
    check_eq("t4_level", level, 5'd1);
    check_eq("t4_retired", retired_count, 32'd1);
    check_eq("t4_halted", halted, 1'b1);
    check_eq("t4_last", out_last, 1'b1);
    drain("t4_drained");
    drive(1'b1, 1'b0, 32'h80);
    tick();
    tick();
    check_eq("t4_drained_halted", halted, 1'b1);
    check_eq("t4_drained_retired", retired_count, 32'd1);
    check_eq("t4_drained_level", level, 5'd0);

    // Exception arriving at a full FIFO is lost.
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b0, 32'(i * 4));
      tick();
    end
    drive(1'b1, 1'b1, 32'h200);
    tick();
    drive(1'b0, 1'b0, 32'h0);
    tick();
    check_eq("t5_last_lost", last_lost, 1'b1);
    check_eq("t5_dropped", dropped_count, 32'd1);
    check_eq("t5_halted", halted, 1'b1);
    drain("t5_drained");
    check_eq("t5_halted_after", halted, 1'b1);

    // Reset in the middle of a drain, coincident with push and pop.
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 1'b0, 32'(32'h1000 + i * 4));
      tick();
    end
    drive(1'b0, 1'b0, 32'h0);
    out_ready = 1'b1;
    tick();
    tick();
    check_eq("t6_level_before", level, 5'd5);
    drive(1'b1, 1'b0, 32'h300);
    do_reset();
    drive(1'b0, 1'b0, 32'h0);
    out_ready = 1'b0;
    check_eq("t6_level", level, 5'd0);
    check_eq("t6_out_valid", out_valid, 1'b0);
    check_eq("t6_retired", retired_count, 32'd0);
    check_eq("t6_dropped", dropped_count, 32'd0);
    check_eq("t6_halted", halted, 1'b0);
    drive(1'b1, 1'b0, 32'h400);
    tick();
    drive(1'b0, 1'b0, 32'h0);
    tick();
    check_eq("t6_seq", out_seq, 32'd0);
    check_eq("t6_pc", out_pc, 32'h400);
    check_eq("t6_level_after", level, 5'd1);

    // Random traffic against the scoreboard.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 1)), 1'b0, $urandom());
      out_ready = ($urandom_range(0, 2) == 0);
      tick();
    end
    drain("rand_drained");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
